// File: rtl/snes_pad_responder.sv
// SNES controller target: latches a 12-button snapshot and shifts it out active-low on controller clock.
// Optional glitch filter on synced latch/clock enabled by defining SNES_PAD_RESPONDER_FILTER_EN.
module snes_pad_responder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] buttons,
  input  logic        ctrl_latch,
  input  logic        ctrl_clock,
  output logic        ctrl_data,
  output logic        busy,
  output logic [4:0]  bit_index,
  output logic        frame_done
);

  localparam int unsigned CNT_W   = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clock_sync;
  logic                   latch_s;
  logic                   clock_s;
  logic                   clock_prev;
  logic                   clock_rise;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latch_sync <= '0;
      clock_sync <= '1;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], ctrl_latch};
      clock_sync <= {clock_sync[SYNC_STAGES-2:0], ctrl_clock};
    end
  end

`ifdef SNES_PAD_RESPONDER_FILTER_EN
  // Bit 0 = latch, bit 1 = clock. Filtered level follows the input only when
  // the current and two previous synced samples agree; otherwise it holds.
  logic [1:0] raw_s;
  logic [1:0] hist1;
  logic [1:0] hist2;
  logic [1:0] filt_q;
  logic [1:0] filt;

  assign raw_s = {clock_sync[SYNC_STAGES-1], latch_sync[SYNC_STAGES-1]};

  always_comb begin
    filt = (raw_s & hist1 & hist2) | (filt_q & (raw_s | hist1 | hist2));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist1  <= 2'b10;
      hist2  <= 2'b10;
      filt_q <= 2'b10;
    end else begin
      hist1  <= raw_s;
      hist2  <= hist1;
      filt_q <= filt;
    end
  end

  assign latch_s = filt[0];
  assign clock_s = filt[1];
`else
  assign latch_s = latch_sync[SYNC_STAGES-1];
  assign clock_s = clock_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clock_prev <= 1'b1;
    end else begin
      clock_prev <= clock_s;
    end
  end

  assign clock_rise = clock_s & ~clock_prev;

  state_t            state_q, state_n;
  logic [15:0]       shift_q, shift_n;
  logic [4:0]        index_q, index_n;
  logic              done_q, done_n;
  logic              data_q;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [15:0]       load_word;

  assign load_word = {4'hF, ~buttons};

  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    index_n = index_q;
    done_n  = 1'b0;
    cnt_n   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (latch_s) begin
          state_n = S_LOAD;
          shift_n = load_word;
          index_n = '0;
        end
      end
      S_LOAD: begin
        index_n = '0;
        if (latch_s) begin
          shift_n = load_word;
        end else begin
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Latch takes priority over a simultaneous clock edge.
        if (latch_s) begin
          state_n = S_LOAD;
          shift_n = load_word;
          index_n = '0;
        end else if (clock_rise) begin
          shift_n = {1'b0, shift_q[15:1]};
          index_n = index_q + 5'd1;
          if (index_q == 5'd15) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end
        end else if ((IDLE_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          state_n = S_IDLE;
          shift_n = '1;
          index_n = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (latch_s) begin
          state_n = S_LOAD;
          shift_n = load_word;
          index_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        shift_n = '1;
        index_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '1;
      index_q <= '0;
      done_q  <= 1'b0;
      data_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      index_q <= index_n;
      done_q  <= done_n;
      data_q  <= shift_q[0];
      cnt_q   <= cnt_n;
    end
  end

  assign ctrl_data  = data_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign bit_index  = index_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: frames, re-latch, coincident latch/clock, timeout, reset.
`timescale 1ns/1ps
module tb_snes_pad_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] buttons = 12'h000;
  logic        ctrl_latch = 1'b0;
  logic        ctrl_clock = 1'b1;
  logic        ctrl_data;
  logic        busy;
  logic [4:0]  bit_index;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int fd_total = 0;

  snes_pad_responder #(
    .SYNC_STAGES (2),
    .IDLE_TIMEOUT(100)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .buttons   (buttons),
    .ctrl_latch(ctrl_latch),
    .ctrl_clock(ctrl_clock),
    .ctrl_data (ctrl_data),
    .busy      (busy),
    .bit_index (bit_index),
    .frame_done(frame_done)
  );

  always #50 clock = ~clock;

  always @(negedge clock) begin
    if (frame_done === 1'b1) fd_total++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_latch();
    ctrl_latch = 1'b1;
    wait_cyc(120);
    ctrl_latch = 1'b0;
    wait_cyc(30);
  endtask

  task automatic pulse(output logic d);
    ctrl_clock = 1'b0;
    wait_cyc(30);
    d = ctrl_data;
    ctrl_clock = 1'b1;
    wait_cyc(30);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(3);
    checks++; if (ctrl_data !== 1'b1) begin errors++; $display("FAIL reset_data got %b exp 1", ctrl_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bit_index !== 5'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", bit_index); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
    reset = 1'b0;
    wait_cyc(200);
    checks++; if (ctrl_data !== 1'b1) begin errors++; $display("FAIL idle_data got %b exp 1", ctrl_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    checks++; if (bit_index !== 5'd0) begin errors++; $display("FAIL idle_index got %0d exp 0", bit_index); end
    checks++; if (fd_total !== 0) begin errors++; $display("FAIL idle_done_count got %0d exp 0", fd_total); end
  endtask

  task automatic test_frame_b();
    logic [15:0] exp_word;
    logic        d;
    int          base;
    exp_word = 16'hFFFE;
    buttons  = 12'h001;
    base     = fd_total;
    do_latch();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b_busy got %b exp 1", busy); end
    for (int i = 0; i < 16; i++) begin
      pulse(d);
      checks++; if (d !== exp_word[i]) begin errors++; $display("FAIL b_bit%0d got %b exp %b", i, d, exp_word[i]); end
      checks++; if (bit_index !== 5'(i + 1)) begin errors++; $display("FAIL b_index%0d got %0d exp %0d", i, bit_index, i + 1); end
    end
    checks++; if (fd_total - base !== 1) begin errors++; $display("FAIL b_done_count got %0d exp 1", fd_total - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b_done_busy got %b exp 0", busy); end
    pulse(d);
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL b_bit16 got %b exp 0", d); end
    checks++; if (bit_index !== 5'd16) begin errors++; $display("FAIL b_index_sat got %0d exp 16", bit_index); end
    checks++; if (fd_total - base !== 1) begin errors++; $display("FAIL b_done_once got %0d exp 1", fd_total - base); end
  endtask

  task automatic test_frame_a5a();
    logic [15:0] exp_word;
    logic        d;
    int          base;
    exp_word = 16'hF5A5;
    buttons  = 12'hA5A;
    base     = fd_total;
    do_latch();
    for (int i = 0; i < 16; i++) begin
      if (i == 4) buttons = 12'h000;
      pulse(d);
      checks++; if (d !== exp_word[i]) begin errors++; $display("FAIL a5a_bit%0d got %b exp %b", i, d, exp_word[i]); end
      checks++; if (bit_index !== 5'(i + 1)) begin errors++; $display("FAIL a5a_index%0d got %0d exp %0d", i, bit_index, i + 1); end
    end
    checks++; if (fd_total - base !== 1) begin errors++; $display("FAIL a5a_done_count got %0d exp 1", fd_total - base); end
  endtask

  task automatic test_relatch();
    logic [15:0] exp_word;
    logic        d;
    int          base;
    exp_word = 16'hF7FF;
    buttons  = 12'hA5A;
    base     = fd_total;
    do_latch();
    for (int i = 0; i < 5; i++) pulse(d);
    buttons    = 12'h800;
    ctrl_latch = 1'b1;
    wait_cyc(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL relatch_busy got %b exp 1", busy); end
    checks++; if (bit_index !== 5'd0) begin errors++; $display("FAIL relatch_index got %0d exp 0", bit_index); end
    wait_cyc(100);
    ctrl_latch = 1'b0;
    wait_cyc(30);
    checks++; if (fd_total - base !== 0) begin errors++; $display("FAIL relatch_no_done got %0d exp 0", fd_total - base); end
    for (int i = 0; i < 16; i++) begin
      pulse(d);
      checks++; if (d !== exp_word[i]) begin errors++; $display("FAIL relatch_bit%0d got %b exp %b", i, d, exp_word[i]); end
    end
    checks++; if (fd_total - base !== 1) begin errors++; $display("FAIL relatch_done_count got %0d exp 1", fd_total - base); end
  endtask

  task automatic test_coincident();
    logic d;
    buttons = 12'h001;
    do_latch();
    for (int i = 0; i < 3; i++) pulse(d);
    ctrl_clock = 1'b0;
    wait_cyc(30);
    ctrl_latch = 1'b1;
    ctrl_clock = 1'b1;
    wait_cyc(10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coin_busy got %b exp 1", busy); end
    checks++; if (bit_index !== 5'd0) begin errors++; $display("FAIL coin_index got %0d exp 0", bit_index); end
    checks++; if (ctrl_data !== 1'b0) begin errors++; $display("FAIL coin_data got %b exp 0", ctrl_data); end
    ctrl_clock = 1'b0;
    wait_cyc(10);
    ctrl_clock = 1'b1;
    wait_cyc(10);
    checks++; if (bit_index !== 5'd0) begin errors++; $display("FAIL load_ignore_index got %0d exp 0", bit_index); end
    checks++; if (ctrl_data !== 1'b0) begin errors++; $display("FAIL load_ignore_data got %b exp 0", ctrl_data); end
    ctrl_latch = 1'b0;
    wait_cyc(30);
    pulse(d);
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL coin_bit0 got %b exp 0", d); end
    checks++; if (bit_index !== 5'd1) begin errors++; $display("FAIL coin_index1 got %0d exp 1", bit_index); end
    wait_cyc(150);
  endtask

  task automatic test_timeout();
    logic d;
    int   base;
    buttons = 12'h001;
    base    = fd_total;
    do_latch();
    for (int i = 0; i < 3; i++) pulse(d);
    wait_cyc(60);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_before got %b exp 1", busy); end
    checks++; if (bit_index !== 5'd3) begin errors++; $display("FAIL to_index_before got %0d exp 3", bit_index); end
    wait_cyc(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_after got %b exp 0", busy); end
    checks++; if (ctrl_data !== 1'b1) begin errors++; $display("FAIL to_data_after got %b exp 1", ctrl_data); end
    checks++; if (fd_total - base !== 0) begin errors++; $display("FAIL to_no_done got %0d exp 0", fd_total - base); end
  endtask

`ifdef SNES_PAD_RESPONDER_FILTER_EN
  task automatic test_filter_glitch();
    buttons = 12'h001;
    do_latch();
    ctrl_clock = 1'b0;
    wait_cyc(2);
    ctrl_clock = 1'b1;
    wait_cyc(20);
    checks++; if (bit_index !== 5'd0) begin errors++; $display("FAIL glitch_index got %0d exp 0", bit_index); end
    checks++; if (ctrl_data !== 1'b0) begin errors++; $display("FAIL glitch_data got %b exp 0", ctrl_data); end
    wait_cyc(150);
  endtask
`endif

  task automatic test_async_reset();
    logic d;
    buttons = 12'h001;
    do_latch();
    for (int i = 0; i < 4; i++) pulse(d);
    @(negedge clock);
    #10 reset = 1'b1;
    #1;
    checks++; if (ctrl_data !== 1'b1) begin errors++; $display("FAIL ares_data got %b exp 1", ctrl_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ares_busy got %b exp 0", busy); end
    checks++; if (bit_index !== 5'd0) begin errors++; $display("FAIL ares_index got %0d exp 0", bit_index); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ares_done got %b exp 0", frame_done); end
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ares_stay_idle got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_frame_b();
    test_frame_a5a();
    test_relatch();
    test_coincident();
    test_timeout();
`ifdef SNES_PAD_RESPONDER_FILTER_EN
    test_filter_glitch();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
